// File: rtl/data_island_packet_deserializer_pkg.sv
// Shared constants, FSM state type and serial BCH helpers for the data island
// packet deserializer.
package data_island_packet_deserializer_pkg;

    localparam int PACKET_CLOCKS        = 32;
    localparam int HEADER_DATA_BITS     = 24;
    localparam int SUBPACKET_DATA_BITS  = 56;
    localparam int ECC_BITS             = 8;
    localparam int SUBPACKETS           = 4;
    localparam int HEADER_DATA_CLOCKS   = 24;
    localparam int SUBPACKET_DATA_CLOCKS = 28;

    localparam logic [ECC_BITS-1:0] BCH_POLY = 8'h83;
    localparam logic [4:0] LAST_CLOCK        = 5'(PACKET_CLOCKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECEIVE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // One serial step of the BCH accumulator for data bit d.
    function automatic logic [ECC_BITS-1:0] bch_step(input logic [ECC_BITS-1:0] ecc,
                                                     input logic d);
        logic fb;
        fb = d ^ ecc[0];
        if (fb) begin
            return {1'b0, ecc[ECC_BITS-1:1]} ^ BCH_POLY;
        end else begin
            return {1'b0, ecc[ECC_BITS-1:1]};
        end
    endfunction

    // Syndrome produced by a single flipped data bit at position pos of a
    // data_bits long block: inject a 1 at that step, zeros afterwards.
    function automatic logic [ECC_BITS-1:0] bch_signature(input int data_bits, input int pos);
        logic [ECC_BITS-1:0] s;
        s = bch_step(8'h00, 1'b1);
        for (int i = pos + 1; i < data_bits; i++) begin
            s = bch_step(s, 1'b0);
        end
        return s;
    endfunction

endpackage

// File: rtl/data_island_packet_deserializer_bch_ecc_checker.sv
// Serial BCH checker for one ECC block (header: 1 bit/clock over 24 clocks,
// subpacket: 2 bits/clock over 28 clocks). Accumulates the ECC over the data
// clocks, collects the received ECC over the remaining clocks and exposes the
// syndrome. With ECC_CORRECT_EN defined it also exposes a one-hot mask of the
// single bit position (data then ECC) whose signature matches the syndrome.
module data_island_packet_deserializer_bch_ecc_checker
    import data_island_packet_deserializer_pkg::*;
#(
    parameter int BITS_PER_CLOCK = 1,
    parameter int DATA_CLOCKS    = 24
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      sample,
    input  logic                      first,
    input  logic [4:0]                slot,
    input  logic [BITS_PER_CLOCK-1:0] bits,
    output logic [ECC_BITS-1:0]       syndrome
`ifdef ECC_CORRECT_EN
    ,
    output logic [BITS_PER_CLOCK*DATA_CLOCKS+ECC_BITS-1:0] correct_mask
`endif
);

    localparam int         DATA_BITS  = BITS_PER_CLOCK * DATA_CLOCKS;
    localparam logic [4:0] DATA_SLOTS = 5'(DATA_CLOCKS);

    logic [ECC_BITS-1:0] acc_r;
    logic [ECC_BITS-1:0] rx_r;
    logic [ECC_BITS-1:0] acc_base_s;
    logic [ECC_BITS-1:0] acc_next_s;

    // Next accumulator value: restart from zero on packet clock 0, even bit first.
    always_comb begin
        if (first) begin
            acc_base_s = 8'h00;
        end else begin
            acc_base_s = acc_r;
        end
        acc_next_s = acc_base_s;
        for (int b = 0; b < BITS_PER_CLOCK; b++) begin
            acc_next_s = bch_step(acc_next_s, bits[b]);
        end
    end

    // Accumulate during data clocks, shift received ECC in LSB first afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_r <= 8'h00;
            rx_r  <= 8'h00;
        end else if (sample) begin
            if (slot < DATA_SLOTS) begin
                acc_r <= acc_next_s;
            end else begin
                rx_r <= {bits, rx_r[ECC_BITS-1:BITS_PER_CLOCK]};
            end
        end
    end

    assign syndrome = acc_r ^ rx_r;

`ifdef ECC_CORRECT_EN
    for (genvar p = 0; p < DATA_BITS; p++) begin : g_data_sig
        localparam logic [ECC_BITS-1:0] SIG = bch_signature(DATA_BITS, p);
        assign correct_mask[p] = (syndrome == SIG);
    end
    for (genvar j = 0; j < ECC_BITS; j++) begin : g_ecc_sig
        assign correct_mask[DATA_BITS+j] = (syndrome == (8'h01 << j));
    end
`endif

endmodule

// File: rtl/data_island_packet_deserializer.sv
// Data island packet deserializer: rebuilds the 24-bit header and four 56-bit
// subpackets from 32 clocks of decoded TERC4 nibbles, checks every BCH block
// and presents the packet with status as a one-cycle pulse.
// Optional feature macro: ECC_CORRECT_EN (single-bit correction, one extra
// pipeline stage). Without it the block detects only and reports raw data.
module data_island_packet_deserializer
    import data_island_packet_deserializer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        terc4Valid,
    input  logic [3:0]  terc4channel0,
    input  logic [3:0]  terc4channel1,
    input  logic [3:0]  terc4channel2,
    output logic [23:0] header,
    output logic [55:0] subpacket0,
    output logic [55:0] subpacket1,
    output logic [55:0] subpacket2,
    output logic [55:0] subpacket3,
    output logic        packetValid,
    output logic        headerEccOk,
    output logic [3:0]  subpacketEccOk,
    output logic        framingError,
    output logic        hsync,
    output logic        vsync
);

    localparam logic [4:0] HDR_SLOTS = 5'(HEADER_DATA_CLOCKS);
    localparam logic [4:0] SP_SLOTS  = 5'(SUBPACKET_DATA_CLOCKS);

    state_t     state_r, state_s;
    logic [4:0] count_r, count_s;
    logic       start_s, sample_s, first_s, done_s, framing_s;
    logic [4:0] slot_s;

    logic [HEADER_DATA_BITS-1:0]    hdr_shift_r;
    logic [SUBPACKET_DATA_BITS-1:0] sp_shift_r [SUBPACKETS];

    logic [ECC_BITS-1:0]   hdr_syn_s;
    logic [ECC_BITS-1:0]   sp_syn_s [SUBPACKETS];
    logic                  hdr_ok_s;
    logic [SUBPACKETS-1:0] sp_ok_s;

    logic [HEADER_DATA_BITS-1:0]    header_r;
    logic [SUBPACKET_DATA_BITS-1:0] sp_out_r [SUBPACKETS];
    logic                           packet_valid_r;
    logic                           header_ok_r;
    logic [SUBPACKETS-1:0]          sp_ok_r;
    logic                           framing_r;
    logic                           hsync_r;
    logic                           vsync_r;

    // A clock-0 symbol is the only one with channel 0 bit 3 cleared.
    assign start_s = terc4Valid & ~terc4channel0[3];

    // FSM state and symbol counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= 5'd0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
        end
    end

    // Next state, symbol acceptance and framing decisions.
    always_comb begin
        state_s   = state_r;
        count_s   = count_r;
        sample_s  = 1'b0;
        first_s   = 1'b0;
        done_s    = 1'b0;
        framing_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    sample_s = 1'b1;
                    first_s  = 1'b1;
                    count_s  = 5'd1;
                    state_s  = ST_RECEIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECEIVE: begin
                if (!terc4Valid) begin
                    framing_s = 1'b1;
                    count_s   = 5'd0;
                    state_s   = ST_IDLE;
                end else if (!terc4channel0[3]) begin
                    // Early restart: this symbol is clock 0 of a new packet.
                    framing_s = 1'b1;
                    sample_s  = 1'b1;
                    first_s   = 1'b1;
                    count_s   = 5'd1;
                    state_s   = ST_RECEIVE;
                end else begin
                    sample_s = 1'b1;
                    if (count_r == LAST_CLOCK) begin
                        count_s = 5'd0;
                        state_s = ST_DONE;
                    end else begin
                        count_s = count_r + 5'd1;
                        state_s = ST_RECEIVE;
                    end
                end
            end
            ST_DONE: begin
                done_s = 1'b1;
                if (start_s) begin
                    // Back-to-back packet: accept its clock 0 right away.
                    sample_s = 1'b1;
                    first_s  = 1'b1;
                    count_s  = 5'd1;
                    state_s  = ST_RECEIVE;
                end else begin
                    count_s = 5'd0;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                count_s = 5'd0;
                state_s = ST_IDLE;
            end
        endcase
        if (first_s) begin
            slot_s = 5'd0;
        end else begin
            slot_s = count_r;
        end
    end

    // Shift header and subpacket data bits in LSB first during their data clocks.
    always_ff @(posedge clock) begin
        if (reset) begin
            hdr_shift_r <= '0;
            for (int i = 0; i < SUBPACKETS; i++) begin
                sp_shift_r[i] <= '0;
            end
        end else if (sample_s) begin
            if (slot_s < HDR_SLOTS) begin
                hdr_shift_r <= {terc4channel0[2], hdr_shift_r[HEADER_DATA_BITS-1:1]};
            end
            if (slot_s < SP_SLOTS) begin
                for (int i = 0; i < SUBPACKETS; i++) begin
                    sp_shift_r[i] <= {terc4channel2[i], terc4channel1[i],
                                      sp_shift_r[i][SUBPACKET_DATA_BITS-1:2]};
                end
            end
        end
    end

`ifdef ECC_CORRECT_EN
    logic [HEADER_DATA_BITS+ECC_BITS-1:0]    hdr_mask_s;
    logic [SUBPACKET_DATA_BITS+ECC_BITS-1:0] sp_mask_s [SUBPACKETS];
`endif

    data_island_packet_deserializer_bch_ecc_checker #(
        .BITS_PER_CLOCK (1),
        .DATA_CLOCKS    (HEADER_DATA_CLOCKS)
    ) u_hdr_chk (
        .clock    (clock),
        .reset    (reset),
        .sample   (sample_s),
        .first    (first_s),
        .slot     (slot_s),
        .bits     (terc4channel0[2]),
        .syndrome (hdr_syn_s)
`ifdef ECC_CORRECT_EN
        ,
        .correct_mask (hdr_mask_s)
`endif
    );

    for (genvar i = 0; i < SUBPACKETS; i++) begin : g_sp_chk
        data_island_packet_deserializer_bch_ecc_checker #(
            .BITS_PER_CLOCK (2),
            .DATA_CLOCKS    (SUBPACKET_DATA_CLOCKS)
        ) u_sp_chk (
            .clock    (clock),
            .reset    (reset),
            .sample   (sample_s),
            .first    (first_s),
            .slot     (slot_s),
            .bits     ({terc4channel2[i], terc4channel1[i]}),
            .syndrome (sp_syn_s[i])
`ifdef ECC_CORRECT_EN
            ,
            .correct_mask (sp_mask_s[i])
`endif
        );
    end

    // Clean-syndrome flags per ECC block.
    always_comb begin
        hdr_ok_s = (hdr_syn_s == 8'h00);
        for (int i = 0; i < SUBPACKETS; i++) begin
            sp_ok_s[i] = (sp_syn_s[i] == 8'h00);
        end
    end

`ifdef ECC_CORRECT_EN
    logic                                    pipe_valid_r;
    logic [HEADER_DATA_BITS-1:0]             pipe_hdr_r;
    logic                                    pipe_hdr_ok_r;
    logic [HEADER_DATA_BITS+ECC_BITS-1:0]    pipe_hdr_mask_r;
    logic [SUBPACKET_DATA_BITS-1:0]          pipe_sp_r [SUBPACKETS];
    logic [SUBPACKETS-1:0]                   pipe_sp_ok_r;
    logic [SUBPACKET_DATA_BITS+ECC_BITS-1:0] pipe_sp_mask_r [SUBPACKETS];

    // Capture raw packet, clean flags and correction masks at the end of a packet.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid_r    <= 1'b0;
            pipe_hdr_r      <= '0;
            pipe_hdr_ok_r   <= 1'b0;
            pipe_hdr_mask_r <= '0;
            pipe_sp_ok_r    <= 4'h0;
            for (int i = 0; i < SUBPACKETS; i++) begin
                pipe_sp_r[i]      <= '0;
                pipe_sp_mask_r[i] <= '0;
            end
        end else begin
            pipe_valid_r <= done_s;
            if (done_s) begin
                pipe_hdr_r      <= hdr_shift_r;
                pipe_hdr_ok_r   <= hdr_ok_s;
                pipe_hdr_mask_r <= hdr_mask_s;
                pipe_sp_ok_r    <= sp_ok_s;
                for (int i = 0; i < SUBPACKETS; i++) begin
                    pipe_sp_r[i]      <= sp_shift_r[i];
                    pipe_sp_mask_r[i] <= sp_mask_s[i];
                end
            end
        end
    end

    // Apply single-bit corrections and publish the packet one stage later.
    always_ff @(posedge clock) begin
        if (reset) begin
            packet_valid_r <= 1'b0;
            header_r       <= '0;
            header_ok_r    <= 1'b0;
            sp_ok_r        <= 4'h0;
            for (int i = 0; i < SUBPACKETS; i++) begin
                sp_out_r[i] <= '0;
            end
        end else begin
            packet_valid_r <= pipe_valid_r;
            if (pipe_valid_r) begin
                header_r    <= pipe_hdr_r ^ pipe_hdr_mask_r[HEADER_DATA_BITS-1:0];
                header_ok_r <= pipe_hdr_ok_r | (|pipe_hdr_mask_r);
                for (int i = 0; i < SUBPACKETS; i++) begin
                    sp_out_r[i] <= pipe_sp_r[i] ^ pipe_sp_mask_r[i][SUBPACKET_DATA_BITS-1:0];
                    sp_ok_r[i]  <= pipe_sp_ok_r[i] | (|pipe_sp_mask_r[i]);
                end
            end
        end
    end
`else
    // Publish the raw packet and clean flags in the cycle after DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            packet_valid_r <= 1'b0;
            header_r       <= '0;
            header_ok_r    <= 1'b0;
            sp_ok_r        <= 4'h0;
            for (int i = 0; i < SUBPACKETS; i++) begin
                sp_out_r[i] <= '0;
            end
        end else begin
            packet_valid_r <= done_s;
            if (done_s) begin
                header_r    <= hdr_shift_r;
                header_ok_r <= hdr_ok_s;
                sp_ok_r     <= sp_ok_s;
                for (int i = 0; i < SUBPACKETS; i++) begin
                    sp_out_r[i] <= sp_shift_r[i];
                end
            end
        end
    end
`endif

    // Framing pulse and sync flags, tracked independently of the packet FSM.
    always_ff @(posedge clock) begin
        if (reset) begin
            framing_r <= 1'b0;
            hsync_r   <= 1'b0;
            vsync_r   <= 1'b0;
        end else begin
            framing_r <= framing_s;
            if (terc4Valid) begin
                hsync_r <= terc4channel0[0];
                vsync_r <= terc4channel0[1];
            end
        end
    end

    assign header         = header_r;
    assign subpacket0     = sp_out_r[0];
    assign subpacket1     = sp_out_r[1];
    assign subpacket2     = sp_out_r[2];
    assign subpacket3     = sp_out_r[3];
    assign packetValid    = packet_valid_r;
    assign headerEccOk    = header_ok_r;
    assign subpacketEccOk = sp_ok_r;
    assign framingError   = framing_r;
    assign hsync          = hsync_r;
    assign vsync          = vsync_r;

endmodule
